// File: rtl/avl_adc_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : avl_adc_monitor
//  Purpose  : Avalon-MM register front end for a multi-channel SPI ADC
//             sequencer. Keeps the latest sample per channel and captures
//             coherent whole-scan snapshots. Each channel is checked against
//             an upper threshold with a debounce counter. A trip is sticky
//             and drives the fault vector and the interrupt.
//  Ports    : clk, reset_n               clock, async active-low reset
//             address/writedata/write_n/
//             read_n/readdata           Avalon-MM slave (registered read)
//             irq                       level interrupt = |(FLAG & IE)
//             s_valid/s_channel/s_data  sample stream from the sequencer
//             core_en                   CR.EN, goes to the sequencer
//             fault                     per-channel sticky trip flags
//  Revision : 1.0  initial release
// ============================================================================
module avl_adc_monitor #(
    parameter int NUM_CH    = 8,
    parameter int ADC_WIDTH = 12,
    parameter int DB_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [5:0]           address,
    input  logic [31:0]          writedata,
    input  logic                 write_n,
    input  logic                 read_n,
    output logic [31:0]          readdata,
    output logic                 irq,
    input  logic                 s_valid,
    input  logic [3:0]           s_channel,
    input  logic [ADC_WIDTH-1:0] s_data,
    output logic                 core_en,
    output logic [NUM_CH-1:0]    fault
);

    // Bus values are left-justified in bits [15:0].
    localparam int PAD = 16 - ADC_WIDTH;

    typedef enum logic [1:0] {
        SNAP_IDLE  = 2'd0,
        SNAP_ARMED = 2'd1,
        SNAP_SCAN  = 2'd2
    } snap_state_t;

    logic                 en;
    logic [NUM_CH-1:0]    ie_trip;
    logic                 ie_snap;
    logic [NUM_CH-1:0]    flag_trip;
    logic                 flag_snap;
    logic [DB_WIDTH-1:0]  debounce;
    logic [ADC_WIDTH-1:0] thresh   [NUM_CH];
    logic [ADC_WIDTH-1:0] live     [NUM_CH];
    logic [ADC_WIDTH-1:0] snapshot [NUM_CH];
    logic [DB_WIDTH-1:0]  cnt      [NUM_CH];
    snap_state_t          snap_state;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic wr, wr_cr, wr_tr, wr_ie, wr_flag, wr_deb, wr_thr;
    logic snap_req, clr;

    assign wr       = ~write_n;
    assign wr_cr    = wr && (address == 6'h00);
    assign wr_tr    = wr && (address == 6'h01);
    assign wr_ie    = wr && (address == 6'h02);
    assign wr_flag  = wr && (address == 6'h03);
    assign wr_deb   = wr && (address == 6'h04);
    assign wr_thr   = wr && (address[5:4] == 2'b01);
    assign snap_req = wr_tr && writedata[0];
    assign clr      = wr_tr && writedata[6];

    logic unused_wd;
    assign unused_wd = &{1'b0, writedata};

    logic [NUM_CH-1:0] w1c_trip;
    logic              w1c_snap;
    assign w1c_trip = wr_flag ? writedata[NUM_CH-1:0] : '0;
    assign w1c_snap = wr_flag && writedata[31];

    // A programmed debounce of 0 is treated as 1.
    logic [DB_WIDTH-1:0] deb_eff;
    assign deb_eff = (debounce == '0) ? DB_WIDTH'(1) : debounce;

    // ------------------------------------------------------------------
    // Per-channel sample match, debounce counters and trip detection
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0]    hit;
    logic [NUM_CH-1:0]    trip_set;
    logic [DB_WIDTH-1:0]  cnt_nxt  [NUM_CH];
    logic [ADC_WIDTH-1:0] snap_val [NUM_CH];

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            hit[ch]      = s_valid && (s_channel == 4'(ch));
            cnt_nxt[ch]  = cnt[ch];
            trip_set[ch] = 1'b0;
            if (!en || clr) begin
                cnt_nxt[ch] = '0;
            end else if (hit[ch]) begin
                if (s_data > thresh[ch]) begin
                    cnt_nxt[ch]  = (cnt[ch] == '1) ? cnt[ch] : cnt[ch] + DB_WIDTH'(1);
                    trip_set[ch] = (cnt_nxt[ch] >= deb_eff);
                end else begin
                    cnt_nxt[ch] = '0;
                end
            end
            // The closing sample of a scan is captured together with LIVE.
            snap_val[ch] = hit[ch] ? s_data : live[ch];
        end
    end

    // ------------------------------------------------------------------
    // Snapshot capture condition
    // ------------------------------------------------------------------
    logic ch0_smp, last_smp, capture;
    assign ch0_smp  = s_valid && (s_channel == 4'd0);
    assign last_smp = s_valid && (s_channel == 4'(NUM_CH - 1));

    always_comb begin
        capture = 1'b0;
        case (snap_state)
            SNAP_ARMED: capture = ch0_smp && (NUM_CH == 1);
            SNAP_SCAN:  capture = last_smp;
            default:    capture = 1'b0;
        endcase
        if (clr) capture = 1'b0;
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    function automatic logic [31:0] ljust(input logic [ADC_WIDTH-1:0] v);
        return 32'(v) << PAD;
    endfunction

    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        if (address[5:4] == 2'b00) begin
            case (address[3:0])
                4'h0: rd_val[0] = en;
                4'h2: begin
                    rd_val[NUM_CH-1:0] = ie_trip;
                    rd_val[31]         = ie_snap;
                end
                4'h3: begin
                    rd_val[NUM_CH-1:0] = flag_trip;
                    rd_val[31]         = flag_snap;
                end
                4'h4: rd_val[DB_WIDTH-1:0] = debounce;
                default: rd_val = '0;
            endcase
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (address[3:0] == 4'(ch)) begin
                    case (address[5:4])
                        2'b01:   rd_val = ljust(thresh[ch]);
                        2'b10:   rd_val = ljust(snapshot[ch]);
                        default: rd_val = ljust(live[ch]);
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en         <= 1'b0;
            ie_trip    <= '0;
            ie_snap    <= 1'b0;
            flag_trip  <= '0;
            flag_snap  <= 1'b0;
            debounce   <= DB_WIDTH'(1);
            snap_state <= SNAP_IDLE;
            irq        <= 1'b0;
            readdata   <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                thresh[ch]   <= '1;
                live[ch]     <= '0;
                snapshot[ch] <= '0;
                cnt[ch]      <= '0;
            end
        end else begin
            if (wr_cr) en <= writedata[0];
            if (wr_ie) begin
                ie_trip <= writedata[NUM_CH-1:0];
                ie_snap <= writedata[31];
            end
            if (wr_deb && !en) debounce <= writedata[DB_WIDTH-1:0];

            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (wr_thr && (address[3:0] == 4'(ch)) && !en)
                    thresh[ch] <= writedata[15 -: ADC_WIDTH];
                if (hit[ch]) live[ch] <= s_data;
                if (capture) snapshot[ch] <= snap_val[ch];
                cnt[ch] <= cnt_nxt[ch];
            end

            // Sets beat a same-cycle W1C; CLR beats everything.
            flag_trip <= clr ? '0   : ((flag_trip & ~w1c_trip) | trip_set);
            flag_snap <= clr ? 1'b0 : ((flag_snap & ~w1c_snap) | capture);

            if (clr) begin
                snap_state <= SNAP_IDLE;
            end else begin
                case (snap_state)
                    SNAP_IDLE:  if (snap_req) snap_state <= SNAP_ARMED;
                    SNAP_ARMED: if (ch0_smp)
                                    snap_state <= (NUM_CH == 1) ? SNAP_IDLE : SNAP_SCAN;
                    SNAP_SCAN:  if (last_smp) snap_state <= SNAP_IDLE;
                    default:    snap_state <= SNAP_IDLE;
                endcase
            end

            irq <= |{flag_trip & ie_trip, flag_snap & ie_snap};

            if (!read_n) readdata <= rd_val;
        end
    end

    assign core_en = en;
    assign fault   = flag_trip;

endmodule
`default_nettype wire

// File: tb/tb_avl_adc_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_avl_adc_monitor
//  Purpose  : Directed self-checking bench for avl_adc_monitor
//             (NUM_CH=8, ADC_WIDTH=12, DB_WIDTH=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_avl_adc_monitor;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  address = '0;
    logic [31:0] writedata = '0;
    logic        write_n = 1'b1;
    logic        read_n = 1'b1;
    logic [31:0] readdata;
    logic        irq;
    logic        s_valid = 1'b0;
    logic [3:0]  s_channel = '0;
    logic [11:0] s_data = '0;
    logic        core_en;
    logic [7:0]  fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avl_adc_monitor #(.NUM_CH(8), .ADC_WIDTH(12), .DB_WIDTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .writedata (writedata),
        .write_n   (write_n),
        .read_n    (read_n),
        .readdata  (readdata),
        .irq       (irq),
        .s_valid   (s_valid),
        .s_channel (s_channel),
        .s_data    (s_data),
        .core_en   (core_en),
        .fault     (fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One bus/sample cycle: optional write and optional sample in the same clock.
    task automatic cycle(input logic wr, input logic [5:0] a, input logic [31:0] d,
                         input logic sv, input logic [3:0] ch, input logic [11:0] sd);
        @(posedge clk); #1;
        write_n   = ~wr;
        address   = a;
        writedata = d;
        s_valid   = sv;
        s_channel = ch;
        s_data    = sd;
        @(posedge clk); #1;
        write_n = 1'b1;
        s_valid = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        cycle(1'b1, a, d, 1'b0, 4'd0, 12'd0);
    endtask

    task automatic smp(input logic [3:0] ch, input logic [11:0] sd);
        cycle(1'b0, 6'd0, 32'd0, 1'b1, ch, sd);
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] q);
        @(posedge clk); #1;
        read_n  = 1'b0;
        address = a;
        @(posedge clk); #1;
        read_n = 1'b1;
        q      = readdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] q;
    logic [11:0] t2_vals [6];

    initial begin
        t2_vals = '{12'h801, 12'h801, 12'h800, 12'h801, 12'h801, 12'h801};

        // ---------------- 1: reset mid-scan ----------------
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        wr(6'h11, 32'h0000_0000);      // THRESH[1]=0 so ch1 trips at once
        wr(6'h02, 32'h0000_0002);
        wr(6'h00, 32'h1);
        wr(6'h01, 32'h1);              // SNAP armed
        smp(4'd0, 12'h123);
        smp(4'd1, 12'h222);
        rd(6'h30, q);
        check("pre_live0", q, 32'h0000_1230);
        check("pre_fault", 32'(fault), 32'h02);
        @(posedge clk); #3 reset_n = 1'b0;
        #1;
        check("rst_readdata", readdata, 32'h0);
        check("rst_core_en", 32'(core_en), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        rd(6'h13, q); check("rst_thresh3", q, 32'h0000_FFF0);
        rd(6'h11, q); check("rst_thresh1", q, 32'h0000_FFF0);
        rd(6'h04, q); check("rst_debounce", q, 32'h1);
        rd(6'h03, q); check("rst_flag", q, 32'h0);
        rd(6'h30, q); check("rst_live0", q, 32'h0);

        // ---------------- 2: threshold + debounce ----------------
        wr(6'h12, 32'h0000_8000);      // THRESH[2]=0x800
        wr(6'h04, 32'h3);
        wr(6'h02, 32'h4);
        wr(6'h00, 32'h1);
        for (int i = 0; i < 6; i++) begin
            smp(4'd2, t2_vals[i]);
            check($sformatf("t2_fault_s%0d", i), 32'(fault), (i == 5) ? 32'h04 : 32'h00);
        end
        check("t2_irq_latency", 32'(irq), 32'h0);
        @(posedge clk); #1;
        check("t2_irq_set", 32'(irq), 32'h1);
        rd(6'h03, q); check("t2_flag", q, 32'h4);
        wr(6'h03, 32'h4);
        @(posedge clk); #1;
        check("t2_irq_clr", 32'(irq), 32'h0);
        check("t2_fault_clr", 32'(fault), 32'h0);

        // ---------------- 3: THRESH lock while enabled ----------------
        wr(6'h10, 32'h0000_1000);
        rd(6'h10, q); check("t3_locked", q, 32'h0000_FFF0);
        wr(6'h00, 32'h0);
        check("t3_core_en", 32'(core_en), 32'h0);
        wr(6'h10, 32'h0000_1000);
        rd(6'h10, q); check("t3_written", q, 32'h0000_1000);

        // ---------------- 4: snapshot ----------------
        wr(6'h02, 32'h8000_0000);
        for (int i = 0; i < 5; i++) smp(4'(i), 12'h300 + 12'(i));
        wr(6'h01, 32'h1);              // SNAP in the middle of a scan
        for (int i = 5; i < 8; i++) smp(4'(i), 12'h555);
        rd(6'h03, q); check("t4_armed_noflag", q, 32'h0);
        for (int i = 0; i < 8; i++) smp(4'(i), 12'hA00 + 12'(i));
        rd(6'h03, q); check("t4_flag31", q, 32'h8000_0000);
        rd(6'h27, q); check("t4_snap7", q, 32'h0000_A070);
        rd(6'h25, q); check("t4_snap5", q, 32'h0000_A050);
        rd(6'h20, q); check("t4_snap0", q, 32'h0000_A000);
        check("t4_irq", 32'(irq), 32'h1);
        smp(4'd7, 12'h111);
        rd(6'h37, q); check("t4_live7", q, 32'h0000_1110);
        rd(6'h27, q); check("t4_snap7_held", q, 32'h0000_A070);

        // ---------------- 5: W1C / CLR vs same-cycle trip ----------------
        wr(6'h03, 32'h8000_0000);
        wr(6'h02, 32'h0);
        wr(6'h11, 32'h0000_1000);      // THRESH[1]=0x100
        wr(6'h04, 32'h1);
        wr(6'h00, 32'h1);
        cycle(1'b1, 6'h03, 32'h2, 1'b1, 4'd1, 12'h200);
        check("t5_set_beats_w1c", 32'(fault), 32'h02);
        cycle(1'b1, 6'h01, 32'h40, 1'b1, 4'd1, 12'h200);
        check("t5_clr_beats_set", 32'(fault), 32'h00);
        rd(6'h03, q); check("t5_flag", q, 32'h0);

        // ---------------- 6: out-of-range channel ----------------
        rd(6'h31, q); check("t6_live1_before", q, 32'h0000_2000);
        smp(4'd9, 12'hFFF);
        check("t6_fault", 32'(fault), 32'h0);
        rd(6'h29, q); check("t6_live9", q, 32'h0);
        rd(6'h31, q); check("t6_live1_after", q, 32'h0000_2000);
        rd(6'h01, q); check("t6_tr_read", q, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
